// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: freeze/flush/bubble sequencing for a 5-stage MIPS pipeline.
// Control outputs are combinational (same cycle); the watchdog and counters are registered.
// Optional feature macro FORWARDING_EN: when defined, only load-use hazards stall.
module hazard_stall_ctrl #(
  parameter int unsigned MAX_WAIT = 64,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_two_src,
  input  logic [4:0]       ex_dest,
  input  logic             ex_wb_en,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_freeze,
  output logic             ifid_freeze,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic             in_mem_wait,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

  state_e           state_q;
  logic [15:0]      wait_cnt_q;
  logic             mem_timeout_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic mem_stall;
  logic hazard;

  // Register 0 is hard-wired zero, so a dependency on it is never real.
  function automatic logic src_match(input logic [4:0] d, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic two);
    return (d != 5'd0) && ((d == s1) || (two && (d == s2)));
  endfunction

  assign mem_stall = mem_req & ~mem_ready;

`ifdef FORWARDING_EN
  // ALU results are forwarded; only a load in EX cannot supply its data in time.
  logic unused_fwd;
  assign unused_fwd = ^{mem_dest, mem_wb_en};
  assign hazard = ex_mem_read & ex_wb_en & src_match(ex_dest, id_src1, id_src2, id_two_src);
`else
  // No bypass network: any pending write in EX or MEM blocks the reader in ID.
  logic unused_nofwd;
  assign unused_nofwd = ex_mem_read;
  assign hazard = (ex_wb_en  & src_match(ex_dest,  id_src1, id_src2, id_two_src))
                | (mem_wb_en & src_match(mem_dest, id_src1, id_src2, id_two_src));
`endif

  // Stage-register controls, priority memory wait > taken branch > data hazard.
  always_comb begin
    pc_freeze   = 1'b0;
    ifid_freeze = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        // Whole pipe holds; a taken branch stays in frozen EX and acts after release.
        pc_freeze   = 1'b1;
        ifid_freeze = 1'b1;
        pipe_freeze = 1'b1;
      end else if (br_taken) begin
        // Wrong-path ID instruction is squashed, so its hazard is irrelevant.
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (hazard) begin
        pc_freeze   = 1'b1;
        ifid_freeze = 1'b1;
        idex_bubble = 1'b1;
      end
    end
  end

  // RUN/MEM_WAIT sequencing with the saturating wait counter and sticky timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= 16'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          wait_cnt_q <= 16'd0;
          if (mem_stall) begin
            state_q <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_q    <= RUN;
            wait_cnt_q <= 16'd0;
          end else begin
            if (wait_cnt_q != 16'hFFFF) begin
              wait_cnt_q <= wait_cnt_q + 16'd1;
            end
            // Flag only; the stall itself continues until the SRAM answers.
            if (wait_cnt_q >= WAIT_LAST) begin
              mem_timeout_q <= 1'b1;
            end
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Saturating performance counters of freeze and flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_freeze && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (ifid_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign in_mem_wait  = (state_q == MEM_WAIT);
  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed cases then randomized traffic against a reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Built with MAX_WAIT=4 and CNT_W=4 so the watchdog and counter saturation are reachable quickly.
module tb_hazard_stall_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_src1, id_src2, ex_dest, mem_dest;
  logic             id_two_src, ex_wb_en, ex_mem_read, mem_wb_en;
  logic             br_taken, mem_req, mem_ready;
  logic             pc_freeze, ifid_freeze, ifid_flush, idex_bubble, pipe_freeze;
  logic             in_mem_wait, mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: plain integers, not the RTL encoding.
  bit m_wait = 0;
  int m_run  = 0;   // consecutive unanswered cycles spent waiting
  bit m_to   = 0;
  int m_stall = 0;
  int m_flush = 0;

  hazard_stall_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_freeze(pc_freeze), .ifid_freeze(ifid_freeze), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
    .in_mem_wait(in_mem_wait), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit reads(input logic [4:0] d);
    return (d != 0) && ((d == id_src1) || (id_two_src && (d == id_src2)));
  endfunction

  function automatic bit ref_hazard();
`ifdef FORWARDING_EN
    return ex_mem_read && ex_wb_en && reads(ex_dest);
`else
    return (ex_wb_en && reads(ex_dest)) || (mem_wb_en && reads(mem_dest));
`endif
  endfunction

  // Expected {pc_freeze, ifid_freeze, ifid_flush, idex_bubble, pipe_freeze}.
  function automatic logic [4:0] ref_ctrl();
    if (rst) return 5'b00000;
    if (mem_req && !mem_ready) return 5'b11001;
    if (br_taken) return 5'b00110;
    if (ref_hazard()) return 5'b11010;
    return 5'b00000;
  endfunction

  task automatic check_model();
    logic [4:0] e;
    e = ref_ctrl();
    chk("pc_freeze",   32'(pc_freeze),   32'(e[4]));
    chk("ifid_freeze", 32'(ifid_freeze), 32'(e[3]));
    chk("ifid_flush",  32'(ifid_flush),  32'(e[2]));
    chk("idex_bubble", 32'(idex_bubble), 32'(e[1]));
    chk("pipe_freeze", 32'(pipe_freeze), 32'(e[0]));
    chk("in_mem_wait", 32'(in_mem_wait), rst ? 32'd0 : 32'(m_wait));
    chk("mem_timeout", 32'(mem_timeout), rst ? 32'd0 : 32'(m_to));
    chk("stall_cycles", 32'(stall_cycles), rst ? 32'd0 : 32'(m_stall));
    chk("flush_count",  32'(flush_count),  rst ? 32'd0 : 32'(m_flush));
  endtask

  // Advance the model across one rising edge using the inputs held this cycle.
  task automatic model_edge();
    logic [4:0] e;
    e = ref_ctrl();
    if (rst) begin
      m_wait = 0; m_run = 0; m_to = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (e[4] && m_stall < CNT_MAX) m_stall++;
      if (e[2] && m_flush < CNT_MAX) m_flush++;
      if (m_wait) begin
        if (mem_ready) begin
          m_wait = 0;
          m_run  = 0;
        end else begin
          m_run++;
          if (m_run >= MAX_WAIT) m_to = 1;
        end
      end else if (mem_req && !mem_ready) begin
        m_wait = 1;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    id_src1 = 0; id_src2 = 0; id_two_src = 0; ex_dest = 0; ex_wb_en = 0;
    ex_mem_read = 0; mem_dest = 0; mem_wb_en = 0; br_taken = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    // Reset with a live load-use hazard on the inputs: controls must still be 0.
    idle_inputs();
    rst = 1'b1;
    ex_mem_read = 1; ex_wb_en = 1; ex_dest = 5; id_src1 = 5;
    #2;
    chk("rst_pc_freeze", 32'(pc_freeze), 0);
    chk("rst_bubble", 32'(idex_bubble), 0);
    chk("rst_stall_cnt", 32'(stall_cycles), 0);
    chk("rst_wait", 32'(in_mem_wait), 0);
    sample(); advance(); advance();
    rst = 1'b0;

    // Load-use: one cycle of freeze + bubble, stall counter +1.
    sample();
    chk("lu_pc_freeze", 32'(pc_freeze), 1);
    chk("lu_bubble", 32'(idex_bubble), 1);
    chk("lu_pipe_freeze", 32'(pipe_freeze), 0);
    advance();
    idle_inputs();
    sample();
    chk("lu_stall_cnt", 32'(stall_cycles), 1);
    advance();

    // r0 destination never stalls.
    ex_mem_read = 1; ex_wb_en = 1; ex_dest = 0; id_src1 = 0;
    sample();
    chk("r0_pc_freeze", 32'(pc_freeze), 0);
    chk("r0_bubble", 32'(idex_bubble), 0);
    advance();

    // Taken branch overrides a hazard.
    ex_dest = 5; id_src1 = 5; br_taken = 1;
    sample();
    chk("br_flush", 32'(ifid_flush), 1);
    chk("br_bubble", 32'(idex_bubble), 1);
    chk("br_pc_freeze", 32'(pc_freeze), 0);
    advance();
    idle_inputs();
    sample();
    chk("br_flush_cnt", 32'(flush_count), 1);
    advance();

    // SRAM wait: request for 5 cycles, ready on the 5th.
    for (int c = 1; c <= 5; c++) begin
      mem_req = 1; mem_ready = (c == 5);
      sample();
      chk("sram_pipe_freeze", 32'(pipe_freeze), (c <= 4) ? 1 : 0);
      chk("sram_in_wait", 32'(in_mem_wait), (c >= 2) ? 1 : 0);
      chk("sram_timeout", 32'(mem_timeout), 0);
      advance();
    end
    idle_inputs();
    sample(); advance();

    // Watchdog: 1 RUN cycle + 4 MEM_WAIT cycles, timeout visible on cycle 6.
    for (int c = 1; c <= 8; c++) begin
      mem_req = 1; mem_ready = (c == 7);
      sample();
      chk("wd_timeout", 32'(mem_timeout), (c >= 6) ? 1 : 0);
      chk("wd_freeze", 32'(pc_freeze), (c == 7) ? 0 : 1);
      advance();
    end
    idle_inputs();
    sample();
    chk("wd_sticky", 32'(mem_timeout), 1);
    advance();

    // ALU-result dependency on rt: stalls only without forwarding.
    ex_wb_en = 1; ex_mem_read = 0; ex_dest = 7; id_src2 = 7; id_two_src = 1; id_src1 = 3;
    sample();
`ifdef FORWARDING_EN
    chk("nofwd_pc_freeze", 32'(pc_freeze), 0);
`else
    chk("nofwd_pc_freeze", 32'(pc_freeze), 1);
`endif
    advance();

    // Only reset clears the timeout.
    idle_inputs();
    rst = 1'b1;
    sample();
    chk("rst_clears_timeout", 32'(mem_timeout), 0);
    advance();
    rst = 1'b0;

    // Randomized traffic, including occasional mid-run resets.
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      id_src1     = 5'($urandom_range(0, 3));
      id_src2     = 5'($urandom_range(0, 3));
      id_two_src  = 1'($urandom_range(0, 1));
      ex_dest     = 5'($urandom_range(0, 3));
      ex_wb_en    = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      mem_dest    = 5'($urandom_range(0, 3));
      mem_wb_en   = 1'($urandom_range(0, 1));
      br_taken    = ($urandom_range(0, 6) == 0);
      mem_req     = ($urandom_range(0, 2) == 0) || (in_mem_wait && $urandom_range(0, 3) != 0);
      mem_ready   = ($urandom_range(0, 4) == 0);
      sample();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
